// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit whose results commit to HI/LO when busy falls
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        readSel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi, r_lo, r_thi, r_tlo;
    logic          r_dz;
    logic          w_busy, w_acc, w_isdiv, w_move, w_m1;
    logic [63:0]   w_smul, w_umul, w_res;
    logic signed [31:0] w_d1s, w_d2s;
    logic [31:0]   w_d2u, w_squo, w_srem, w_uquo, w_urem;
    assign w_busy  = r_cnt != '0;
    assign w_acc   = start && !w_busy && op >= 3'd1 && op <= 3'd4;
    assign w_isdiv = op[1] & op[0] | op[2];
    assign w_move  = !w_busy && !start;
    assign w_m1    = &D2;
    assign w_smul  = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
    assign w_umul  = {32'b0, D1} * {32'b0, D2};
    // divisors of 0 and -1 are substituted so the divider never sees a trapping case
    assign w_d1s   = $signed(D1);
    assign w_d2s   = (D2 == '0 || w_m1) ? 32'sd1 : $signed(D2);
    assign w_d2u   = (D2 == '0) ? 32'd1 : D2;
    assign w_squo  = w_m1 ? 32'(32'd0 - D1) : 32'(w_d1s / w_d2s);
    assign w_srem  = w_m1 ? 32'd0 : 32'(w_d1s % w_d2s);
    assign w_uquo  = D1 / w_d2u;
    assign w_urem  = D1 % w_d2u;
    always_comb begin
        w_res = (op == OP_MULT)  ? w_smul :
                (op == OP_MULTU) ? w_umul :
                (op == OP_DIV)   ? {w_srem, w_squo} : {w_urem, w_uquo};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_thi <= '0;
            r_tlo <= '0;
            r_dz  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_cnt <= w_isdiv ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                r_thi <= w_res[63:32];
                r_tlo <= w_res[31:0];
                r_dz  <= w_isdiv && D2 == '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_cnt == CW'(1) && !r_dz) begin
                r_hi <= r_thi;
                r_lo <= r_tlo;
            end else if (w_move && op == OP_MTHI) begin
                r_hi <= D1;
            end else if (w_move && op == OP_MTLO) begin
                r_lo <= D1;
            end
        end
    end
    assign busy  = w_busy;
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign MDOut = readSel ? r_hi : r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors against a cycle-level behavioural model plus literal checks
module tb_mult_div_unit;
    logic        clk = 0, reset = 1, start = 0, readSel = 0;
    logic [2:0]  op = 0;
    logic [31:0] D1 = 0, D2 = 0;
    logic        busy;
    logic [31:0] HI, LO, MDOut;
    int checks = 0, failures = 0;
    bit mon = 0;
    int m_left = 0;
    bit m_pv = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_ph = 0, m_pl = 0;

    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .D1(D1), .D2(D2),
        .readSel(readSel), .busy(busy), .HI(HI), .LO(LO), .MDOut(MDOut)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] golden(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qa, ra;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        if (o == 3'd1) r = 64'(sa * sb);
        else if (o == 3'd2) r = {32'b0, a} * {32'b0, b};
        else if (o == 3'd3 && b != 0) begin
            qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
            ra = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
            r = {32'(sa < 0 ? -ra : ra), 32'(((sa < 0) != (sb < 0)) ? -qa : qa)};
        end else if (o == 3'd4 && b != 0) r = {a % b, a / b};
        return r;
    endfunction

    always @(posedge clk) begin
        logic [63:0] g;
        if (reset) begin
            m_left = 0; m_pv = 0; m_hi = 0; m_lo = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pv) begin m_hi = m_ph; m_lo = m_pl; end
        end else if (start && op >= 1 && op <= 4) begin
            m_left = (op >= 3) ? 10 : 5;
            g = golden(op, D1, D2);
            m_ph = g[63:32]; m_pl = g[31:0];
            m_pv = !(op >= 3 && D2 == 0);
        end else if (!start && op == 5) m_hi = D1;
        else if (!start && op == 6) m_lo = D1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (mon) begin
        chk("model_busy", {31'b0, busy}, {31'b0, m_left != 0});
        chk("model_HI", HI, m_hi);
        chk("model_LO", LO, m_lo);
        chk("model_MDOut", MDOut, readSel ? m_hi : m_lo);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1; op = o; D1 = a; D2 = b;
        tick();
        start = 0; op = 0;
    endtask

    task automatic run_len(input string name, input int exp);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin n++; tick(); end
        chk(name, 32'(n), 32'(exp));
    endtask

    initial begin
        tick(); tick();
        reset = 0;
        mon = 1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_MDOut", MDOut, 32'd0);
        issue(1, 32'hFFFFFFFD, 32'd5);
        chk("mult_hold_HI", HI, 32'd0);
        run_len("mult_len", 5);
        chk("mult_HI", HI, 32'hFFFFFFFF);
        chk("mult_LO", LO, 32'hFFFFFFF1);
        issue(2, 32'hFFFFFFFF, 32'd2);
        chk("multu_hold_LO", LO, 32'hFFFFFFF1);
        run_len("multu_len", 5);
        chk("multu_HI", HI, 32'd1);
        chk("multu_LO", LO, 32'hFFFFFFFE);
        issue(4, 32'd7, 32'd0);
        run_len("divu0_len", 10);
        chk("divu0_HI", HI, 32'd1);
        chk("divu0_LO", LO, 32'hFFFFFFFE);
        issue(3, 32'hFFFFFFF9, 32'd2);
        run_len("div_len", 10);
        chk("div_HI", HI, 32'hFFFFFFFF);
        chk("div_LO", LO, 32'hFFFFFFFD);
        issue(3, 32'h80000000, 32'hFFFFFFFF);
        run_len("divovf_len", 10);
        chk("divovf_HI", HI, 32'd0);
        chk("divovf_LO", LO, 32'h80000000);
        issue(4, 32'd100, 32'd7);
        tick();
        issue(1, 32'd3, 32'd4);
        op = 5; D1 = 32'h1234;
        tick();
        op = 0;
        run_len("intf_len", 7);
        chk("intf_HI", HI, 32'd2);
        chk("intf_LO", LO, 32'd14);
        op = 6; D1 = 32'hABCD;
        tick();
        op = 0;
        readSel = 0; #1;
        chk("mtlo_LO", LO, 32'hABCD);
        chk("mtlo_MDOut_lo", MDOut, 32'hABCD);
        readSel = 1; #1;
        chk("mtlo_MDOut_hi", MDOut, 32'd2);
        issue(7, 32'd9, 32'd9);
        chk("rsvd_busy", {31'b0, busy}, 32'd0);
        op = 5; D1 = 32'h55AA; tick(); op = 0;
        chk("mthi_HI", HI, 32'h55AA);
        issue(1, 32'd3, 32'd4);
        tick(); tick();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1; tick(); reset = 0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_HI", HI, 32'd0);
        chk("abort_LO", LO, 32'd0);
        repeat (8) tick();
        chk("late_HI", HI, 32'd0);
        chk("late_LO", LO, 32'd0);
        mon = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
